// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Multi-cycle instruction sequencer for the GameBoy CPU core.
//               Steps each opcode through FETCH/DECODE/EXECUTE/WRITE for a
//               variable number of iterations. It stalls on memory wait
//               states, handles the 0xCB prefix and HALT, and dispatches
//               interrupts at instruction boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
  parameter int ITER_W     = 3,
  parameter int NUM_IRQ    = 5,
  parameter int IRQ_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         op_code,
  input  logic [ITER_W-1:0]  op_iters,
  input  logic               op_cond_en,
  input  logic [1:0]         op_cond,
  input  logic [ITER_W-1:0]  cond_iters,
  input  logic               op_mem,
  input  logic               op_halt,
  input  logic [3:0]         flags,
  input  logic               mem_ready,
  input  logic [NUM_IRQ-1:0] irq_pending,
  input  logic               ime,
  output logic [2:0]         state,
  output logic [ITER_W-1:0]  iteration,
  output logic               prefix_cb,
  output logic               fetch_op_code,
  output logic               mem_req,
  output logic               instr_done,
  output logic               halted,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [7:0]         irq_vector
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_HALT    = 3'd4,
    S_IRQ     = 3'd5
  } state_t;

  localparam logic [7:0]        c_cb_prefix    = 8'hCB;
  localparam logic [7:0]        c_vector_base  = 8'h40;
  localparam logic [ITER_W-1:0] c_iter_one     = {{(ITER_W-1){1'b0}}, 1'b1};
  localparam logic [ITER_W-1:0] c_iter_zero    = '0;
  localparam logic [3:0]        c_irq_last     = 4'(IRQ_CYCLES - 1);

  // Registered state
  state_t              r_state;
  logic [ITER_W-1:0]   r_iteration;
  logic                r_prefix_cb;
  logic [ITER_W-1:0]   r_iter_total;
  logic                r_halt_latched;
  logic [3:0]          r_irq_cnt;
  logic [7:0]          r_irq_vector;

  // Combinational helpers
  logic                w_cond_true;
  logic [ITER_W-1:0]   w_total_sel;
  logic [ITER_W-1:0]   w_total;
  logic [ITER_W:0]     w_iter_next;
  logic                w_last_iter;
  logic                w_irq_any;
  logic [NUM_IRQ-1:0]  w_irq_onehot;
  logic [2:0]          w_irq_idx;
  logic [7:0]          w_irq_vec;
  logic                w_irq_first;
  logic                w_fetch_now;
  logic                w_unused_flags;

  // N and H never influence branch conditions
  assign w_unused_flags = ^flags[2:1];

  // Evaluate the branch condition against Z (bit 3) and C (bit 0)
  always_comb begin
    w_cond_true = 1'b0;
    case (op_cond)
      2'd0:    w_cond_true = ~flags[3];
      2'd1:    w_cond_true =  flags[3];
      2'd2:    w_cond_true = ~flags[0];
      default: w_cond_true =  flags[0];
    endcase
  end

  // A failed condition selects the short iteration count; a zero count runs once
  assign w_total_sel = (op_cond_en && !w_cond_true) ? cond_iters : op_iters;
  assign w_total     = (w_total_sel == c_iter_zero) ? c_iter_one : w_total_sel;

  // One bit wider than the counter so the comparison can never wrap
  assign w_iter_next = {1'b0, r_iteration} + 1'b1;
  assign w_last_iter = (w_iter_next >= {1'b0, r_iter_total});

  // Lowest-numbered pending line wins; scanning downwards leaves it last
  always_comb begin
    w_irq_onehot = '0;
    w_irq_idx    = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pending[i]) begin
        w_irq_onehot    = '0;
        w_irq_onehot[i] = 1'b1;
        w_irq_idx       = 3'(i);
      end
    end
  end

  assign w_irq_any   = |irq_pending;
  assign w_irq_vec   = w_irq_any ? (c_vector_base + {2'b00, w_irq_idx, 3'b000}) : 8'h00;
  assign w_irq_first = (r_state == S_IRQ) && (r_irq_cnt == 4'd0);
  assign w_fetch_now = (r_state == S_FETCH) && (r_iteration == c_iter_zero);

  // Outputs decoded from the registered state
  assign state         = r_state;
  assign iteration     = r_iteration;
  assign prefix_cb     = r_prefix_cb;
  assign fetch_op_code = w_fetch_now;
  assign mem_req       = w_fetch_now || ((r_state == S_EXECUTE) && op_mem);
  assign instr_done    = (r_state == S_WRITE) && w_last_iter;
  assign halted        = (r_state == S_HALT);
  assign irq_ack       = w_irq_first ? w_irq_onehot : '0;
  // The vector is shown live in the entry cycle and from the register afterwards
  assign irq_vector    = w_irq_first ? w_irq_vec : r_irq_vector;

  // Sequencer state machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_FETCH;
      r_iteration    <= c_iter_zero;
      r_prefix_cb    <= 1'b0;
      r_iter_total   <= c_iter_one;
      r_halt_latched <= 1'b0;
      r_irq_cnt      <= 4'd0;
      r_irq_vector   <= 8'h00;
    end else begin
      case (r_state)
        S_FETCH: begin
          // Only the first iteration fetches; later ones pass straight through
          if (r_iteration != c_iter_zero) begin
            r_state <= S_DECODE;
          end else if (mem_ready) begin
            r_state <= S_DECODE;
          end
        end

        S_DECODE: begin
          if ((r_iteration == c_iter_zero) && (op_code == c_cb_prefix) && !r_prefix_cb) begin
            r_prefix_cb <= 1'b1;
            r_state     <= S_FETCH;
          end else begin
            if (r_iteration == c_iter_zero) begin
              r_iter_total   <= w_total;
              r_halt_latched <= op_halt;
            end
            r_state <= S_EXECUTE;
          end
        end

        S_EXECUTE: begin
          if (!(op_mem && !mem_ready)) begin
            r_state <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (!w_last_iter) begin
            r_iteration <= w_iter_next[ITER_W-1:0];
            r_state     <= S_FETCH;
          end else begin
            r_iteration <= c_iter_zero;
            r_prefix_cb <= 1'b0;
            if (r_halt_latched) begin
              r_state <= S_HALT;
            end else if (ime && w_irq_any) begin
              r_irq_cnt <= 4'd0;
              r_state   <= S_IRQ;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end

        S_HALT: begin
          // Any pending line wakes the core, even with interrupts disabled
          if (w_irq_any) begin
            r_halt_latched <= 1'b0;
            if (ime) begin
              r_irq_cnt <= 4'd0;
              r_state   <= S_IRQ;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end

        S_IRQ: begin
          if (r_irq_cnt == 4'd0) begin
            r_irq_vector <= w_irq_vec;
          end
          if (r_irq_cnt >= c_irq_last) begin
            r_iteration <= c_iter_zero;
            r_state     <= S_FETCH;
          end else begin
            r_irq_cnt <= r_irq_cnt + 4'd1;
          end
        end

        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_sequencer
// Description : Scoreboard bench for cpu_sequencer. A memory/decode-ROM driver
//               issues directed and random instructions; expected instruction
//               timings, halt lengths and interrupt dispatches are queued at
//               issue time and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_sequencer;

  localparam int ITER_W     = 3;
  localparam int NUM_IRQ    = 5;
  localparam int IRQ_CYCLES = 5;
  localparam int N_RANDOM   = 80;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         op_code;
  logic [ITER_W-1:0]  op_iters;
  logic               op_cond_en;
  logic [1:0]         op_cond;
  logic [ITER_W-1:0]  cond_iters;
  logic               op_mem;
  logic               op_halt;
  logic [3:0]         flags;
  logic               mem_ready;
  logic [NUM_IRQ-1:0] irq_pending;
  logic               ime;
  logic [2:0]         state;
  logic [ITER_W-1:0]  iteration;
  logic               prefix_cb;
  logic               fetch_op_code;
  logic               mem_req;
  logic               instr_done;
  logic               halted;
  logic [NUM_IRQ-1:0] irq_ack;
  logic [7:0]         irq_vector;

  always #5 clk = ~clk;

  cpu_sequencer #(.ITER_W(ITER_W), .NUM_IRQ(NUM_IRQ), .IRQ_CYCLES(IRQ_CYCLES)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .op_iters(op_iters),
    .op_cond_en(op_cond_en), .op_cond(op_cond), .cond_iters(cond_iters),
    .op_mem(op_mem), .op_halt(op_halt), .flags(flags), .mem_ready(mem_ready),
    .irq_pending(irq_pending), .ime(ime), .state(state), .iteration(iteration),
    .prefix_cb(prefix_cb), .fetch_op_code(fetch_op_code), .mem_req(mem_req),
    .instr_done(instr_done), .halted(halted), .irq_ack(irq_ack),
    .irq_vector(irq_vector)
  );

  // One instruction as the memory / decode ROM sees it
  typedef struct packed {
    logic [7:0]      b0;     // opcode (non-CB instruction)
    logic [7:0]      b1;     // second byte of a CB instruction
    logic            cb;
    logic [2:0]      iters;
    logic [2:0]      citers;
    logic            cen;
    logic [1:0]      cond;
    logic [3:0]      flags;
    logic [7:0]      mask;   // per-iteration memory access
    logic [1:0]      wf0;    // wait cycles on first fetch
    logic [1:0]      wf1;    // wait cycles on second (CB) fetch
    logic [7:0][1:0] we;     // wait cycles per execute access
    logic            halt;
    logic [2:0]      idle;   // halt cycles before the wake line rises
    logic [4:0]      wake;
    logic [4:0]      pend;   // lines pending while the instruction runs
    logic            ime;
    logic            drop;   // pending lines vanish on IRQ entry
  } inst_t;

  typedef struct packed {
    int         cycles;
    int         nfetch;
    int         nmem;
    logic [2:0] last;
    logic       cb;
  } exp_t;

  typedef struct packed {
    logic [4:0] ack;
    logic [7:0] vec;
  } irq_t;

  inst_t stim_q[$];
  exp_t  exp_q[$];
  irq_t  irq_q[$];
  int    halt_q[$];
  int    wait_q[$];

  int checks   = 0;
  int failures = 0;
  int n_issued = 0;
  int n_done   = 0;

  bit    drv_en   = 1'b0;
  bit    mon_en   = 1'b0;
  bit    need_new = 1'b1;
  inst_t cur      = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit cond_holds(input logic [1:0] c, input logic [3:0] f);
    case (c)
      2'd0:    return !f[3];
      2'd1:    return f[3];
      2'd2:    return !f[0];
      default: return f[0];
    endcase
  endfunction

  function automatic int ref_iters(input inst_t s);
    int t;
    t = (s.cen && !cond_holds(s.cond, s.flags)) ? int'(s.citers) : int'(s.iters);
    return (t == 0) ? 1 : t;
  endfunction

  function automatic irq_t ref_irq(input logic [4:0] p);
    irq_t r;
    r.ack = '0;
    r.vec = 8'h00;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (p[i]) begin
        r.ack = 5'(1 << i);
        r.vec = 8'(64 + 8 * i);
        break;
      end
    end
    return r;
  endfunction

  // Issue an instruction: plan its wait states and queue every expected outcome
  task automatic issue(input inst_t s);
    exp_t e;
    int   eff;
    int   ex_cycles;
    int   ex_waits;
    irq_t ir;
    eff       = ref_iters(s);
    ex_cycles = 0;
    ex_waits  = 0;
    wait_q.delete();
    wait_q.push_back(int'(s.wf0));
    if (s.cb) wait_q.push_back(int'(s.wf1));
    for (int i = 0; i < eff; i++) begin
      if (s.mask[i]) begin
        wait_q.push_back(int'(s.we[i]));
        ex_cycles += 1 + int'(s.we[i]);
        ex_waits  += int'(s.we[i]);
      end
    end
    e.nfetch = 1 + int'(s.wf0) + (s.cb ? 1 + int'(s.wf1) : 0);
    e.nmem   = e.nfetch + ex_cycles;
    e.cycles = 4 * eff + (s.cb ? 2 : 0) + int'(s.wf0) + (s.cb ? int'(s.wf1) : 0) + ex_waits;
    e.last   = 3'(eff - 1);
    e.cb     = s.cb;
    exp_q.push_back(e);
    if (s.halt) begin
      halt_q.push_back(int'(s.idle) + 1);
      if (s.ime) begin
        ir = s.drop ? irq_t'(0) : ref_irq(s.wake);
        irq_q.push_back(ir);
      end
    end else if (s.ime && (s.pend != 5'd0)) begin
      ir = s.drop ? irq_t'(0) : ref_irq(s.pend);
      irq_q.push_back(ir);
    end
    n_issued++;
  endtask

  function automatic inst_t base_inst();
    inst_t s;
    s       = '0;
    s.iters = 3'd1;
    s.wake  = 5'd1;
    return s;
  endfunction

  function automatic inst_t rand_inst();
    inst_t s;
    s        = '0;
    s.cb     = ($urandom_range(0, 3) == 0);
    s.b0     = 8'($urandom_range(0, 255));
    if (s.b0 == 8'hCB) s.b0 = 8'h00;
    s.b1     = ($urandom_range(0, 4) == 0) ? 8'hCB : 8'($urandom);
    s.iters  = 3'($urandom);
    s.citers = 3'($urandom);
    s.cen    = 1'($urandom_range(0, 1));
    s.cond   = 2'($urandom);
    s.flags  = 4'($urandom);
    s.mask   = 8'($urandom);
    s.wf0    = 2'($urandom);
    s.wf1    = 2'($urandom);
    s.we     = 16'($urandom);
    s.halt   = ($urandom_range(0, 7) == 0);
    s.idle   = 3'($urandom);
    s.wake   = 5'($urandom_range(1, 31));
    s.pend   = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
    s.ime    = 1'($urandom_range(0, 1));
    s.drop   = ($urandom_range(0, 5) == 0);
    return s;
  endfunction

  // ---------------- driver: memory and decode ROM ----------------
  int  n_fetched  = 0;
  int  hcnt       = 0;
  bit  acc_active = 1'b0;
  int  acc_wait   = 0;
  bit  dec_real;

  // Present the current instruction's inputs, then answer memory requests
  always @(negedge clk) begin
    if (drv_en) begin
      if (need_new && state == 3'd0 && stim_q.size() > 0) begin
        cur = stim_q.pop_front();
        issue(cur);
        need_new  = 1'b0;
        n_fetched = 0;
        hcnt      = 0;
      end
      // The real decode of the opcode; the CB prefix decode gets noise
      dec_real = (state == 3'd1) && (iteration == 3'd0) && (!cur.cb || n_fetched >= 2);
      if (state == 3'd1 && iteration == 3'd0)
        op_code = (n_fetched >= 2) ? cur.b1 : (cur.cb ? 8'hCB : cur.b0);
      else
        op_code = 8'($urandom);
      op_iters   = dec_real ? cur.iters  : 3'($urandom);
      cond_iters = dec_real ? cur.citers : 3'($urandom);
      op_cond_en = dec_real ? cur.cen    : 1'($urandom);
      op_cond    = dec_real ? cur.cond   : 2'($urandom);
      flags      = dec_real ? cur.flags  : 4'($urandom);
      op_halt    = dec_real ? cur.halt   : 1'($urandom);
      op_mem     = (state == 3'd2) ? cur.mask[iteration] : 1'($urandom);
      ime        = cur.ime;
      if (state == 3'd4) begin
        irq_pending = (hcnt < int'(cur.idle)) ? 5'd0 : cur.wake;
        hcnt++;
      end else if (state == 3'd5) begin
        irq_pending = cur.drop ? 5'd0 : (cur.halt ? cur.wake : cur.pend);
      end else begin
        irq_pending = cur.pend;
      end
      if (instr_done) need_new = 1'b1;
      #1;
      if (mem_req) begin
        if (!acc_active) begin
          acc_active = 1'b1;
          acc_wait   = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        end
        mem_ready = (acc_wait == 0);
        if (acc_wait == 0) acc_active = 1'b0;
        else acc_wait--;
        if (fetch_op_code && mem_ready) n_fetched++;
      end else begin
        acc_active = 1'b0;
        mem_ready  = 1'($urandom);
      end
    end
  end

  // ---------------- monitor ----------------
  bit   in_instr = 1'b0;
  int   cyc = 0, nf = 0, nm = 0, hc = 0, ic = 0;
  exp_t e_m;
  irq_t i_m = '0;

  // Measure each instruction, halt and IRQ dispatch and compare to the queues
  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      if (!in_instr && state == 3'd0) begin
        in_instr = 1'b1;
        cyc = 0; nf = 0; nm = 0;
        check("prefix_clear_at_start", prefix_cb, 0);
      end
      if (in_instr) begin
        cyc++;
        if (fetch_op_code) nf++;
        if (mem_req) nm++;
        if (instr_done) begin
          in_instr = 1'b0;
          n_done++;
          if (exp_q.size() == 0) begin
            check("unexpected_instr_done", 1, 0);
          end else begin
            e_m = exp_q.pop_front();
            check("instr_cycles", cyc, e_m.cycles);
            check("fetch_cycles", nf, e_m.nfetch);
            check("mem_req_cycles", nm, e_m.nmem);
            check("last_iteration", iteration, e_m.last);
            check("prefix_at_done", prefix_cb, e_m.cb);
          end
        end
      end
      if (halted) begin
        hc++;
      end else if (hc > 0) begin
        if (halt_q.size() == 0) check("unexpected_halt", hc, 0);
        else check("halt_cycles", hc, halt_q.pop_front());
        hc = 0;
      end
      if (state == 3'd5) begin
        if (ic == 0) begin
          if (irq_q.size() == 0) begin
            check("unexpected_irq", 1, 0);
            i_m = '0;
          end else begin
            i_m = irq_q.pop_front();
          end
          check("irq_ack_entry", irq_ack, i_m.ack);
        end else begin
          check("irq_ack_later", irq_ack, 0);
        end
        check("irq_vector", irq_vector, i_m.vec);
        ic++;
      end else begin
        check("irq_ack_idle", irq_ack, 0);
        if (ic > 0) begin
          check("irq_cycles", ic, IRQ_CYCLES);
          ic = 0;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  inst_t d;
  bit    finished;
  bit    reached;

  initial begin
    rst = 1'b1;
    op_code = 8'h00; op_iters = '0; op_cond_en = 1'b0; op_cond = 2'd0;
    cond_iters = '0; op_mem = 1'b0; op_halt = 1'b0; flags = 4'd0;
    mem_ready = 1'b0; irq_pending = '0; ime = 1'b0;
    #8;
    check("rst_state", state, 0);
    check("rst_iteration", iteration, 0);
    check("rst_prefix_cb", prefix_cb, 0);
    check("rst_fetch_op_code", fetch_op_code, 1);
    check("rst_mem_req", mem_req, 1);
    check("rst_instr_done", instr_done, 0);
    check("rst_halted", halted, 0);
    check("rst_irq_ack", irq_ack, 0);
    check("rst_irq_vector", irq_vector, 0);

    // Directed programme
    for (int k = 0; k < 3; k++) stim_q.push_back(base_inst());      // NOPs
    d = base_inst(); d.iters = 3'd3; d.mask = 8'b010; d.we[1] = 2'd2;
    stim_q.push_back(d);                                            // 14 cycles
    d = base_inst(); d.cb = 1'b1; d.b1 = 8'h37; stim_q.push_back(d);
    d = base_inst(); d.cb = 1'b1; d.b1 = 8'hCB; stim_q.push_back(d);
    d = base_inst(); d.cen = 1'b1; d.cond = 2'd1; d.flags = 4'b0000;
    d.iters = 3'd5; d.citers = 3'd2; stim_q.push_back(d);           // 2 iterations
    d.flags = 4'b1000; stim_q.push_back(d);                         // 5 iterations
    d = base_inst(); d.iters = 3'd0; stim_q.push_back(d);           // 0 runs once
    d = base_inst(); d.halt = 1'b1; d.ime = 1'b1; d.idle = 3'd3;
    d.wake = 5'b00110; stim_q.push_back(d);                         // ack 00010, 0x48
    d.ime = 1'b0; stim_q.push_back(d);                              // wake to FETCH
    d = base_inst(); d.ime = 1'b1; d.pend = 5'b10000; stim_q.push_back(d);
    d.drop = 1'b1; stim_q.push_back(d);                             // dropped IRQ
    d = base_inst(); d.iters = 3'd7; d.mask = 8'hFF; d.we = 16'hFFFF;
    stim_q.push_back(d);                                            // max iterations
    for (int k = 0; k < N_RANDOM; k++) stim_q.push_back(rand_inst());

    drv_en = 1'b1;
    mon_en = 1'b1;
    #4 rst = 1'b0;

    finished = 1'b0;
    for (int k = 0; k < 30000; k++) begin
      @(negedge clk);
      #3;
      if (stim_q.size() == 0 && need_new && state == 3'd0 && exp_q.size() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    check("programme_finished", finished, 1);
    drv_en = 1'b0;
    mon_en = 1'b0;
    check("instr_queue_empty", exp_q.size(), 0);
    check("irq_queue_empty", irq_q.size(), 0);
    check("halt_queue_empty", halt_q.size(), 0);
    check("instr_count", n_done, n_issued);

    // Asynchronous reset in the middle of an execute wait
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    op_iters = 3'd3; op_mem = 1'b1; op_cond_en = 1'b0; op_halt = 1'b0;
    ime = 1'b0; irq_pending = '0;
    reached = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      op_code   = prefix_cb ? 8'h37 : 8'hCB;
      mem_ready = !(state == 3'd2 && iteration == 3'd2);
      if (state == 3'd2 && iteration == 3'd2) begin
        reached = 1'b1;
        break;
      end
    end
    check("rst_test_reached_wait", reached, 1);
    repeat (2) @(negedge clk);
    #2;
    check("wait_holds_execute", state, 2);
    check("wait_prefix_set", prefix_cb, 1);
    rst = 1'b1;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_iteration", iteration, 0);
    check("async_rst_prefix_cb", prefix_cb, 0);
    check("async_rst_mem_req", mem_req, 1);
    check("async_rst_fetch", fetch_op_code, 1);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
